// File: rtl/cnn_pkg.sv
// cnn_pkg
//   Shared constants and geometry helpers for the convolution datapath.
//   DW_DEFAULT / FRAC_BITS_DEFAULT : default pixel width and fractional bits
//   padded_dim(n, pad)             : image extent including padding on both sides
//   out_dim(n, pad, k, stride)     : number of window positions along one axis
package cnn_pkg;

  localparam int DW_DEFAULT        = 14;
  localparam int FRAC_BITS_DEFAULT = 7;

  function automatic int padded_dim(input int n, input int pad);
    return n + 2 * pad;
  endfunction

  // Floor division: a partial window at the far edge is not produced.
  function automatic int out_dim(input int n, input int pad, input int k, input int stride);
    return (padded_dim(n, pad) - k) / stride + 1;
  endfunction

endpackage

// File: rtl/window_pos_counter.sv
// window_pos_counter
//   Tracks the padded (row, column) position of the next element to be pushed
//   into the window shift register and decodes what that position means.
//   Ports:
//     clk, rst     : clock, asynchronous active-low reset
//     push         : an element is pushed this cycle; advance the position
//     interior     : current position is a real image pixel (else padding)
//     win_done     : pushing at the current position completes a window
//     frame_last   : current position is the final padded position of a frame
module window_pos_counter
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 224,
  parameter int IMG_H  = 224,
  parameter int K      = 3,
  parameter int PAD    = 1,
  parameter int STRIDE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  output logic interior,
  output logic win_done,
  output logic frame_last
);

  localparam int WP = padded_dim(IMG_W, PAD);
  localparam int HP = padded_dim(IMG_H, PAD);
  localparam int CW = $clog2(WP + 1);
  localparam int RW = $clog2(HP + 1);

  localparam logic [CW-1:0] PC_MAX = CW'(WP - 1);
  localparam logic [CW-1:0] PC_LO  = CW'(PAD);
  localparam logic [CW-1:0] PC_HI  = CW'(PAD + IMG_W);
  localparam logic [CW-1:0] PC_K   = CW'(K - 1);
  localparam logic [RW-1:0] PR_MAX = RW'(HP - 1);
  localparam logic [RW-1:0] PR_LO  = RW'(PAD);
  localparam logic [RW-1:0] PR_HI  = RW'(PAD + IMG_H);
  localparam logic [RW-1:0] PR_K   = RW'(K - 1);

  // Phase bits hold (pos - (K-1)) mod 2; at position 0 that is (K-1) mod 2.
  localparam logic PH0 = 1'((K - 1) % 2);

  logic [CW-1:0] pc_q, pc_d;
  logic [RW-1:0] pr_q, pr_d;
  logic          cph_q, cph_d;
  logic          rph_q, rph_d;
  logic          pc_wrap, pr_wrap;
  logic          col_ok, row_ok;

  assign pc_wrap    = (pc_q == PC_MAX);
  assign pr_wrap    = (pr_q == PR_MAX);
  assign interior   = (pc_q >= PC_LO) && (pc_q < PC_HI) && (pr_q >= PR_LO) && (pr_q < PR_HI);
  assign col_ok     = (STRIDE == 1) || !cph_q;
  assign row_ok     = (STRIDE == 1) || !rph_q;
  assign win_done   = (pc_q >= PC_K) && (pr_q >= PR_K) && col_ok && row_ok;
  assign frame_last = pc_wrap && pr_wrap;

  // Raster advance; wrapping the last row starts the next frame directly.
  always_comb begin
    pc_d  = pc_q;
    pr_d  = pr_q;
    cph_d = cph_q;
    rph_d = rph_q;
    if (push) begin
      if (pc_wrap) begin
        pc_d  = '0;
        cph_d = PH0;
        if (pr_wrap) begin
          pr_d  = '0;
          rph_d = PH0;
        end else begin
          pr_d  = pr_q + 1'b1;
          rph_d = ~rph_q;
        end
      end else begin
        pc_d  = pc_q + 1'b1;
        cph_d = ~cph_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= '0;
      pr_q  <= '0;
      cph_q <= PH0;
      rph_q <= PH0;
    end else begin
      pc_q  <= pc_d;
      pr_q  <= pr_d;
      cph_q <= cph_d;
      rph_q <= rph_d;
    end
  end

endmodule

// File: rtl/window_line_buffer.sv
// window_line_buffer
//   Streaming KxK sliding-window generator with internal zero padding,
//   stride 1 or 2, and valid/ready flow control on both sides.
//   Ports:
//     clk, rst    : clock, asynchronous active-low reset
//     in_pixel    : input pixel, raster order, unpadded
//     in_valid    : in_pixel is valid
//     in_ready    : pixel is accepted this cycle (combinational)
//     out_window  : KxK window, element (r,c) at [(r*K+c)*DW +: DW], r=0 top
//     out_valid   : out_window is valid
//     out_ready   : downstream accepts the window
//     out_last    : final window of a frame
module window_line_buffer
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 224,
  parameter int IMG_H  = 224,
  parameter int K      = 3,
  parameter int PAD    = 1,
  parameter int STRIDE = 1,
  parameter int DW     = DW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     in_pixel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [K*K*DW-1:0] out_window,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int WP = padded_dim(IMG_W, PAD);
  localparam int L  = (K - 1) * WP + K;

  if (!(K == 3 || K == 5 || K == 7)) begin : g_bad_k
    $error("window_line_buffer: K must be 3, 5 or 7");
  end
  if (!(STRIDE == 1 || STRIDE == 2)) begin : g_bad_stride
    $error("window_line_buffer: STRIDE must be 1 or 2");
  end
  if (PAD < 0 || PAD > (K - 1) / 2) begin : g_bad_pad
    $error("window_line_buffer: PAD must lie in 0..(K-1)/2");
  end

  logic [L*DW-1:0] sr_q, sr_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            interior, win_done, frame_last;
  logic            stall, push;
  logic [DW-1:0]   push_data;

  window_pos_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K),
    .PAD    (PAD),
    .STRIDE (STRIDE)
  ) u_pos (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .interior   (interior),
    .win_done   (win_done),
    .frame_last (frame_last)
  );

  // Pad positions push a zero without waiting for upstream; a held window
  // blocks every push so it cannot be overwritten.
  assign stall    = out_valid_q & ~out_ready;
  assign push     = ~stall & (~interior | in_valid);
  assign in_ready = ~stall & interior;

  // sr element 0 is the newest; the window is a set of fixed taps.
  always_comb begin
    push_data   = interior ? in_pixel : '0;
    sr_d        = sr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (push) begin
      sr_d = {sr_q[(L-1)*DW-1:0], push_data};
    end
    if (push && win_done) begin
      out_valid_d = 1'b1;
      out_last_d  = frame_last;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign out_window[(r*K+c)*DW +: DW] = sr_q[((K-1-r)*WP + (K-1-c))*DW +: DW];
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_window_line_buffer.sv
// tb_window_line_buffer
//   Three instances: A (4x4, K3, PAD1, S1), B (4x4, K3, PAD1, S2) and
//   C (6x6, K5, PAD2, S1). Every valid window is compared against a
//   reference computed from the padded image; a table of hand-derived
//   windows pins the known corner values.
module tb_window_line_buffer;

  localparam int DW   = 14;
  localparam int MAXW = 7 * 7 * DW;

  typedef struct packed {
    int img_w;
    int img_h;
    int k;
    int pad;
    int stride;
  } cfg_t;

  localparam cfg_t CFG_A = '{img_w: 4, img_h: 4, k: 3, pad: 1, stride: 1};
  localparam cfg_t CFG_B = '{img_w: 4, img_h: 4, k: 3, pad: 1, stride: 2};
  localparam cfg_t CFG_C = '{img_w: 6, img_h: 6, k: 5, pad: 2, stride: 1};

  typedef struct packed {
    int                  inst;
    int                  win;
    logic [8:0][DW-1:0]  elems;
    logic                last;
  } vec_t;

  logic            clk;
  logic            rst;
  logic [DW-1:0]   in_pixel_a, in_pixel_b, in_pixel_c;
  logic            in_valid_a, in_valid_b, in_valid_c;
  logic            in_ready_a, in_ready_b, in_ready_c;
  logic [9*DW-1:0] out_window_a, out_window_b;
  logic [25*DW-1:0] out_window_c;
  logic            out_valid_a, out_valid_b, out_valid_c;
  logic            out_ready_a, out_ready_b, out_ready_c;
  logic            out_last_a, out_last_b, out_last_c;

  int vectors = 0;
  int miscompares = 0;
  int stream_a[256];
  int stream_b[256];
  int stream_c[256];
  int idx_a, idx_b, idx_c;
  int last_a, last_b, last_c;
  int cap_a[32][9];
  int cap_b[32][9];
  logic cap_last_a[32];
  logic cap_last_b[32];
  bit rnd_ready = 0;
  vec_t tbl[6];

  window_line_buffer #(.IMG_W(4), .IMG_H(4), .K(3), .PAD(1), .STRIDE(1), .DW(DW)) dut_a (
    .clk(clk), .rst(rst), .in_pixel(in_pixel_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_window(out_window_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .out_last(out_last_a));

  window_line_buffer #(.IMG_W(4), .IMG_H(4), .K(3), .PAD(1), .STRIDE(2), .DW(DW)) dut_b (
    .clk(clk), .rst(rst), .in_pixel(in_pixel_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_window(out_window_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_last(out_last_b));

  window_line_buffer #(.IMG_W(6), .IMG_H(6), .K(5), .PAD(2), .STRIDE(1), .DW(DW)) dut_c (
    .clk(clk), .rst(rst), .in_pixel(in_pixel_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .out_window(out_window_c), .out_valid(out_valid_c), .out_ready(out_ready_c), .out_last(out_last_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int px_at(input int inst, input int i);
    if (inst == 0) return stream_a[i];
    if (inst == 1) return stream_b[i];
    return stream_c[i];
  endfunction

  // Element (r,c) of window number idx, taken straight from the padded image.
  function automatic int model_elem(input int inst, input cfg_t c, input int idx, input int r, input int col);
    int wp, hp, owo, oho, per, f, w, y, x;
    wp  = c.img_w + 2 * c.pad;
    hp  = c.img_h + 2 * c.pad;
    owo = (wp - c.k) / c.stride + 1;
    oho = (hp - c.k) / c.stride + 1;
    per = owo * oho;
    f   = idx / per;
    w   = idx % per;
    y   = (w / owo) * c.stride + r - c.pad;
    x   = (w % owo) * c.stride + col - c.pad;
    if (y < 0 || y >= c.img_h || x < 0 || x >= c.img_w) return 0;
    return px_at(inst, f * c.img_w * c.img_h + y * c.img_w + x);
  endfunction

  // out_last only fires when the frame's last window ends on the final padded position.
  function automatic logic model_last(input cfg_t c, input int idx);
    int wp, hp, owo, oho;
    wp  = c.img_w + 2 * c.pad;
    hp  = c.img_h + 2 * c.pad;
    owo = (wp - c.k) / c.stride + 1;
    oho = (hp - c.k) / c.stride + 1;
    return ((idx % (owo * oho)) == owo * oho - 1) &&
           ((wp - c.k) % c.stride == 0) && ((hp - c.k) % c.stride == 0);
  endfunction

  task automatic checkVal(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input int inst, input cfg_t c,
                             input logic [MAXW-1:0] win, input logic last, input int idx);
    bit bad;
    int br, bc, bact, bexp, act_v, exp_v;
    logic exp_last;
    bad = 0;
    br = 0; bc = 0; bact = 0; bexp = 0;
    for (int r = 0; r < c.k; r++) begin
      for (int col = 0; col < c.k; col++) begin
        act_v = int'(win[(r*c.k+col)*DW +: DW]);
        exp_v = model_elem(inst, c, idx, r, col);
        if (act_v != exp_v && !bad) begin
          bad = 1; br = r; bc = col; bact = act_v; bexp = exp_v;
        end
      end
    end
    exp_last = model_last(c, idx);
    vectors++;
    if (bad || last !== exp_last) begin
      miscompares++;
      $display("[TB] FAIL %s window %0d: elem(%0d,%0d) got %0d want %0d, last got %0b want %0b",
               name, idx, br, bc, bact, bexp, last, exp_last);
    end
  endtask

  // Monitors sample mid-cycle; every valid cycle, stalled or not, must show the expected window.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      idx_a = 0; last_a = 0;
    end else if (out_valid_a) begin
      checkOutput("A window", 0, CFG_A, MAXW'(out_window_a), out_last_a, idx_a);
      if (!out_ready_a) begin
        checkVal("A in_ready while stalled", int'(in_ready_a), 0);
      end else begin
        if (idx_a < 32) begin
          for (int e = 0; e < 9; e++) cap_a[idx_a][e] = int'(out_window_a[e*DW +: DW]);
          cap_last_a[idx_a] = out_last_a;
        end
        if (out_last_a) last_a++;
        idx_a++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      idx_b = 0; last_b = 0;
    end else if (out_valid_b) begin
      checkOutput("B window", 1, CFG_B, MAXW'(out_window_b), out_last_b, idx_b);
      if (out_ready_b) begin
        if (idx_b < 32) begin
          for (int e = 0; e < 9; e++) cap_b[idx_b][e] = int'(out_window_b[e*DW +: DW]);
          cap_last_b[idx_b] = out_last_b;
        end
        if (out_last_b) last_b++;
        idx_b++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      idx_c = 0; last_c = 0;
    end else if (out_valid_c) begin
      checkOutput("C window", 2, CFG_C, MAXW'(out_window_c), out_last_c, idx_c);
      if (out_ready_c) begin
        if (idx_c < 36) checkVal("C centre equals pixel", int'(out_window_c[12*DW +: DW]), stream_c[idx_c]);
        if (out_last_c) last_c++;
        idx_c++;
      end
    end
  end

  // Downstream ready for A: always 1, or a 50% coin when rnd_ready is set.
  initial begin
    out_ready_a = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready_a = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Drive n pixels from stream_a[start..] into A, optionally with random idle gaps.
  task automatic applyStimulus(input int start, input int n, input bit gaps);
    bit accepted;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid_a = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      in_valid_a = 1'b1;
      in_pixel_a = DW'(stream_a[start + i]);
      accepted = 0;
      for (int t = 0; t < 200 && !accepted; t++) begin
        @(negedge clk);
        accepted = in_ready_a;
        @(posedge clk);
        #1;
      end
      if (!accepted) checkVal("A pixel accept timeout", 0, 1);
    end
    in_valid_a = 1'b0;
  endtask

  task automatic send_b(input int n);
    bit accepted;
    for (int i = 0; i < n; i++) begin
      in_valid_b = 1'b1;
      in_pixel_b = DW'(stream_b[i]);
      accepted = 0;
      for (int t = 0; t < 200 && !accepted; t++) begin
        @(negedge clk);
        accepted = in_ready_b;
        @(posedge clk);
        #1;
      end
      if (!accepted) checkVal("B pixel accept timeout", 0, 1);
    end
    in_valid_b = 1'b0;
  endtask

  task automatic send_c(input int n);
    bit accepted;
    for (int i = 0; i < n; i++) begin
      in_valid_c = 1'b1;
      in_pixel_c = DW'(stream_c[i]);
      accepted = 0;
      for (int t = 0; t < 200 && !accepted; t++) begin
        @(negedge clk);
        accepted = in_ready_c;
        @(posedge clk);
        #1;
      end
      if (!accepted) checkVal("C pixel accept timeout", 0, 1);
    end
    in_valid_c = 1'b0;
  endtask

  function automatic int win_count(input int inst);
    if (inst == 0) return idx_a;
    if (inst == 1) return idx_b;
    return idx_c;
  endfunction

  task automatic wait_count(input string name, input int inst, input int target);
    for (int t = 0; t < 500 && win_count(inst) < target; t++) @(posedge clk);
    #1;
    checkVal(name, win_count(inst), target);
  endtask

  task automatic check_reset_state();
    checkVal("reset A out_valid", int'(out_valid_a), 0);
    checkVal("reset A out_last", int'(out_last_a), 0);
    checkVal("reset A out_window zero", int'(out_window_a == '0), 1);
    checkVal("reset A in_ready (PAD=1)", int'(in_ready_a), 0);
    checkVal("reset C out_valid", int'(out_valid_c), 0);
    checkVal("reset C in_ready (PAD=2)", int'(in_ready_c), 0);
  endtask

  function automatic vec_t mk(input int inst, input int win,
                              input int e0, input int e1, input int e2,
                              input int e3, input int e4, input int e5,
                              input int e6, input int e7, input int e8,
                              input logic last);
    vec_t v;
    v.inst = inst;
    v.win  = win;
    v.elems[0] = DW'(e0); v.elems[1] = DW'(e1); v.elems[2] = DW'(e2);
    v.elems[3] = DW'(e3); v.elems[4] = DW'(e4); v.elems[5] = DW'(e5);
    v.elems[6] = DW'(e6); v.elems[7] = DW'(e7); v.elems[8] = DW'(e8);
    v.last = last;
    return v;
  endfunction

  task automatic run_table(input bit only_first_a);
    bit bad;
    int act_v;
    logic act_last;
    for (int i = 0; i < 6; i++) begin
      if (!only_first_a || (tbl[i].inst == 0 && tbl[i].win < 16)) begin
        bad = 0;
        for (int e = 0; e < 9; e++) begin
          act_v = (tbl[i].inst == 0) ? cap_a[tbl[i].win][e] : cap_b[tbl[i].win][e];
          if (act_v != int'(tbl[i].elems[e])) bad = 1;
        end
        act_last = (tbl[i].inst == 0) ? cap_last_a[tbl[i].win] : cap_last_b[tbl[i].win];
        vectors++;
        if (bad || act_last !== tbl[i].last) begin
          miscompares++;
          $display("[TB] FAIL table entry %0d (inst %0d window %0d): got elem4 %0d last %0b want elem4 %0d last %0b",
                   i, tbl[i].inst, tbl[i].win,
                   (tbl[i].inst == 0) ? cap_a[tbl[i].win][4] : cap_b[tbl[i].win][4],
                   act_last, int'(tbl[i].elems[4]), tbl[i].last);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0;
    in_pixel_a = '0;   in_pixel_b = '0;   in_pixel_c = '0;
    out_ready_b = 1'b1; out_ready_c = 1'b1;
    for (int i = 0; i < 256; i++) begin
      stream_a[i] = 0; stream_b[i] = 0; stream_c[i] = 0;
      cap_last_a[i % 32] = 1'b0; cap_last_b[i % 32] = 1'b0;
    end
    for (int i = 0; i < 16; i++) stream_a[i] = i + 1;
    for (int i = 0; i < 16; i++) stream_a[16 + i] = 101 + i;
    for (int i = 32; i < 71; i++) stream_a[i] = $urandom_range(1, 16383);
    for (int i = 0; i < 16; i++) stream_b[i] = i + 1;
    for (int i = 0; i < 36; i++) stream_c[i] = i + 1;

    tbl[0] = mk(0, 0,  0, 0, 0,  0, 1, 2,  0, 5, 6,  1'b0);
    tbl[1] = mk(0, 15, 11, 12, 0,  15, 16, 0,  0, 0, 0,  1'b1);
    tbl[2] = mk(0, 16, 0, 0, 0,  0, 101, 102,  0, 105, 106,  1'b0);
    tbl[3] = mk(1, 0,  0, 0, 0,  0, 1, 2,  0, 5, 6,  1'b0);
    tbl[4] = mk(1, 1,  0, 0, 0,  2, 3, 4,  6, 7, 8,  1'b0);
    tbl[5] = mk(1, 3,  6, 7, 8,  10, 11, 12,  14, 15, 16,  1'b0);

    repeat (3) @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Two back-to-back frames on A, one frame each on B and C, all unstalled.
    fork
      applyStimulus(0, 32, 1'b0);
      send_b(16);
      send_c(36);
    join
    wait_count("A windows after two frames", 0, 32);
    wait_count("B windows stride 2", 1, 4);
    wait_count("C windows K5 PAD2", 2, 36);
    checkVal("A out_last pulses", last_a, 2);
    checkVal("B out_last pulses", last_b, 0);
    checkVal("C out_last pulses", last_c, 1);
    run_table(1'b0);

    // Random ready and input gaps over two more frames.
    rnd_ready = 1;
    applyStimulus(32, 32, 1'b1);
    wait_count("A windows after random frames", 0, 64);
    rnd_ready = 0;
    @(posedge clk);
    #1;
    checkVal("A out_last pulses after random frames", last_a, 4);

    // Abort a frame after 7 pixels, then replay the first frame.
    applyStimulus(64, 7, 1'b0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_reset_state();
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(0, 16, 1'b0);
    wait_count("A windows after mid-frame reset", 0, 16);
    checkVal("A out_last pulses after reset", last_a, 1);
    run_table(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/window_line_buffer.md
# window_line_buffer

Streaming K×K sliding-window generator for the convolution datapath. It accepts an unpadded feature-map channel one pixel per transfer, inserts zero padding internally, and emits stride-aligned K×K windows with valid/ready backpressure on both sides. It sits between the activation/feature-map streamer and the depthwise/standard conv MAC arrays. It generalises the fixed 3×3, pad-1, stride-1 window FIFO to arbitrary K, padding, stride and image height, and adds flow control and frame sequencing.

## Interface
- IMG_W, 224: unpadded image width in pixels.
- IMG_H, 224: unpadded image height in pixels.
- K, 3: window size; legal values are 3, 5 and 7.
- PAD, 1: zero padding on each side; 0 ≤ PAD ≤ (K-1)/2.
- STRIDE, 1: window stride; legal values are 1 and 2.
- DW, 14: pixel width, signed Q(DW-FRAC).7 fixed point; data is passed through unmodified.
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-low.
- in_pixel, in, DW: input pixel, raster order.
- in_valid, in, 1: in_pixel is valid.
- in_ready, out, 1: the block accepts in_pixel this cycle.
- out_window, out, K*K*DW: window; element (r,c) is at bits [(r*K+c+1)*DW-1 : (r*K+c)*DW]; r=0 is the top row, c=0 is the left column.
- out_valid, out, 1: out_window is valid.
- out_ready, in, 1: downstream accepts the window.
- out_last, out, 1: qualifies the final window of a frame.

## Operation
- Padded geometry: Wp = IMG_W+2·PAD, Hp = IMG_H+2·PAD. Shift register depth L = (K-1)·Wp + K; sr[0] is the newest element.
- Counters pc ∈ [0,Wp-1] and pr ∈ [0,Hp-1] give the padded position of the next element to push.
- Interior position: PAD ≤ pc < PAD+IMG_W and PAD ≤ pr < PAD+IMG_H. All other positions are pad positions.
- stall = out_valid & ~out_ready.
- push = ~stall & (pad position | in_valid).
  - On a pad position, a zero is pushed and nothing is consumed.
  - On an interior position, in_pixel is pushed and consumed.
- in_ready = ~stall & interior position. This is combinational.
- On push: shift sr, then advance pc. On pc wrap, advance pr. On pr wrap at Hp-1, return to (0,0) and start the next frame with no idle cycle.
- The element pushed at (pr,pc) completes a window when all of these hold:
  - pr ≥ K-1 and pc ≥ K-1
  - (pr-K+1) mod STRIDE = 0
  - (pc-K+1) mod STRIDE = 0
- Window tap: out_window(r,c) = sr[(K-1-r)·Wp + (K-1-c)]. It is combinational from sr and stable while stalled.
- out_valid is registered:
  - set on a completing push;
  - cleared on an out_valid & out_ready handshake with no completing push in the same cycle;
  - held otherwise.
- out_last is registered and set together with out_valid when the completing push is at (Hp-1, Wp-1).
- Trailing right and bottom padding is generated without any input. A frame therefore completes after the last pixel without further in_valid.
- sr is not flushed between frames. Window validity depends only on the counters, so no stale data reaches a valid window.
- Modular checks use small counters (a row phase and a column phase); no dividers.

## Timing
- Reset values: sr = 0, pc = pr = 0, out_valid = 0, out_last = 0. in_ready = 1 after reset when PAD = 0, else 0.
- Reset mid-frame aborts the frame; the next accepted pixel is treated as pixel (0,0).
- Latency: out_valid rises on the cycle after the push of the window's bottom-right element.
- Throughput: one push per cycle. An unstalled stride-1 interior stream produces one window per cycle.
- Simultaneous handshake and completing push: out_valid stays 1 and the window advances.
- in_valid with in_ready = 0 is held by upstream (standard valid/ready rules). The input is never dropped.
- Output counts per frame: OWo = (Wp-K)/STRIDE+1 and OHo = (Hp-K)/STRIDE+1, both floor.

## Structure
- Shared package cnn_pkg holds:
  - the DW / FRAC_BITS defaults;
  - a function padded_dim(n, pad);
  - a function out_dim(n, pad, k, stride).
- One sub-module, window_pos_counter, contains pc, pr, the stride phase counters, interior/pad decode, window-complete and frame-last flags. The shift register and taps stay in the top module.
- Elaboration-time checks: $error on illegal K, STRIDE or PAD.

## Test plan
- IMG 4×4, K=3, PAD=1, STRIDE=1, pixels 1..16, out_ready = 1 → 16 windows.
  - First window is [0,0,0, 0,1,2, 0,5,6].
  - Last window is [11,12,0, 15,16,0, 0,0,0] with out_last = 1.
- Same setup with STRIDE=2 → 4 windows, at padded centres (1,1), (1,3), (3,1), (3,3).
  - First window is [0,0,0, 0,1,2, 0,5,6].
- Random out_ready (50%) and random in_valid gaps → the window sequence is identical to the unstalled run; out_window is stable while stalled; no pixel is lost or duplicated.
- Two back-to-back frames → the second frame's first window contains only frame-2 data and zeros; 32 windows in total; exactly 2 out_last pulses.
- rst asserted after 7 pixels, then a full frame → outputs are 0 during reset; the post-reset frame matches the first scenario exactly.
- K=5, PAD=2, 6×6 ramp → 36 windows; the centre element of window i equals pixel i.
